lieat_ifu_npc_ctrl: RTL

// - IFU next-PC sequencer. Consumes one fetched instruction plus its mini-decode fields, resolves the

---
 rtl/lieat_ifu_npc_pkg.sv | 31 +++
 rtl/lieat_ifu_npc_tgt.sv | 38 +++
 rtl/lieat_ifu_npc_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/lieat_ifu_npc_pkg.sv
// Shared definitions for the IFU next-PC sequencer: datapath width, reset PC,
// FSM state encoding, target-mux selector and the CSR indices it reads.
`ifndef XLEN
`define XLEN 32
`endif

package lieat_ifu_npc_pkg;

  localparam int unsigned       XLEN      = `XLEN;
  localparam logic [XLEN-1:0]   RESET_PC  = 32'h8000_0000;
  localparam logic [11:0]       CSR_MTVEC = 12'h305;
  localparam logic [11:0]       CSR_MEPC  = 12'h341;

  // Sequencer states: IDLE resolves single-cycle classes; the others wait on
  // the regfile, the CSR file or the fence.i drain.
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_RS1_WAIT    = 2'd1,
    ST_CSR_WAIT    = 2'd2,
    ST_FENCEI_WAIT = 2'd3
  } npc_state_e;

  // Which target the combinational mux produces.
  typedef enum logic [1:0] {
    TGT_SEQ    = 2'd0,  // pc + 4
    TGT_PC_IMM = 2'd1,  // pc + imm
    TGT_JALR   = 2'd2,  // (base + imm) & ~1
    TGT_CSR    = 2'd3   // csr_data & ~3
  } tgt_sel_e;

endpackage

// File: rtl/lieat_ifu_npc_tgt.sv
// Combinational next-PC target generator. All adds wrap modulo 2^XLEN.
module lieat_ifu_npc_tgt #(
  parameter int unsigned XLEN = lieat_ifu_npc_pkg::XLEN
) (
  input  lieat_ifu_npc_pkg::tgt_sel_e sel,
  input  logic [XLEN-1:0]             pc,
  input  logic [XLEN-1:0]             imm,
  input  logic [XLEN-1:0]             base,
  input  logic [XLEN-1:0]             csr_data,
  output logic [XLEN-1:0]             target
);
  import lieat_ifu_npc_pkg::*;

  localparam logic [XLEN-1:0] FOUR      = XLEN'(3'd4);
  localparam logic [XLEN-1:0] MASK_BIT0 = ~XLEN'(1'b1);
  localparam logic [XLEN-1:0] MASK_BIT1 = ~XLEN'(2'd3);

  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] pc_imm_s;
  logic [XLEN-1:0] base_imm_s;

  assign pc_plus4_s = pc + FOUR;
  assign pc_imm_s   = pc + imm;
  assign base_imm_s = base + imm;

  // Select the resolved target, applying jalr/CSR alignment masks.
  always_comb begin
    target = pc_plus4_s;
    case (sel)
      TGT_SEQ:    target = pc_plus4_s;
      TGT_PC_IMM: target = pc_imm_s;
      TGT_JALR:   target = base_imm_s & MASK_BIT0;
      TGT_CSR:    target = csr_data & MASK_BIT1;
      default:    target = pc_plus4_s;
    endcase
  end

endmodule

// File: rtl/lieat_ifu_npc_ctrl.sv
// IFU next-PC sequencer: resolves the fetch target for each instruction,
// sequences jalr/CSR/fence.i waits and registers the result for decode.
module lieat_ifu_npc_ctrl #(
  parameter int unsigned     XLEN     = lieat_ifu_npc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = lieat_ifu_npc_pkg::RESET_PC
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            dec_jal,
  input  logic            dec_jalr,
  input  logic            dec_bxx,
  input  logic            dec_csr,
  input  logic [11:0]     dec_csridx,
  input  logic            dec_fencei,
  input  logic [XLEN-1:0] dec_immb,
  input  logic [4:0]      dec_rs1,
  output logic [4:0]      rf_rd_idx,
  input  logic [XLEN-1:0] rf_rd_data,
  input  logic            rf_busy,
  output logic            csr_rd_req,
  output logic [11:0]     csr_rd_idx,
  input  logic            csr_rd_ack,
  input  logic [XLEN-1:0] csr_rd_data,
  output logic            fencei_req,
  input  logic            fencei_done,
  input  logic            flush_valid,
  input  logic [XLEN-1:0] flush_pc,
  output logic [XLEN-1:0] fetch_pc,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_pc
);
  import lieat_ifu_npc_pkg::*;

  npc_state_e      state_r;
  npc_state_e      state_nxt_s;
  tgt_sel_e        tgt_sel_s;
  logic            taken_s;
  logic            resolve_s;
  logic            csr_start_s;
  logic            fencei_start_s;
  logic            slot_free_s;
  logic            rs1_ready_s;
  logic            csr_ack_s;
  logic            fencei_done_s;
  logic [XLEN-1:0] jalr_base_s;
  logic [XLEN-1:0] csr_data_s;
  logic [XLEN-1:0] target_s;
  logic            csr_have_r;     // ack seen while downstream was stalled
  logic [XLEN-1:0] csr_data_r;
  logic            fencei_done_r;  // drain finished while downstream was stalled

  assign slot_free_s   = ~o_valid | o_ready;
  assign rf_rd_idx     = dec_rs1;
  assign rs1_ready_s   = (dec_rs1 == 5'd0) | ~rf_busy;
  assign jalr_base_s   = (dec_rs1 == 5'd0) ? {XLEN{1'b0}} : rf_rd_data;
  // Acks/dones only count while our request is still outstanding.
  assign csr_ack_s     = csr_rd_ack & csr_rd_req;
  assign fencei_done_s = fencei_done & fencei_req;
  assign csr_data_s    = csr_have_r ? csr_data_r : csr_rd_data;
  assign i_ready       = resolve_s;

  lieat_ifu_npc_tgt #(.XLEN(XLEN)) u_tgt (
    .sel      (tgt_sel_s),
    .pc       (i_pc),
    .imm      (dec_immb),
    .base     (jalr_base_s),
    .csr_data (csr_data_s),
    .target   (target_s)
  );

  // Next-state, target selection and resolve decision; flush overrides all.
  always_comb begin
    state_nxt_s    = state_r;
    tgt_sel_s      = TGT_SEQ;
    taken_s        = 1'b0;
    resolve_s      = 1'b0;
    csr_start_s    = 1'b0;
    fencei_start_s = 1'b0;
    if (flush_valid) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!i_valid) begin
            state_nxt_s = ST_IDLE;
          end else if (dec_csr) begin
            csr_start_s = 1'b1;
            state_nxt_s = ST_CSR_WAIT;
          end else if (dec_fencei) begin
            fencei_start_s = 1'b1;
            state_nxt_s    = ST_FENCEI_WAIT;
          end else if (dec_jalr) begin
            tgt_sel_s = TGT_JALR;
            taken_s   = 1'b1;
            if (rs1_ready_s) begin
              resolve_s = slot_free_s;
            end else begin
              state_nxt_s = ST_RS1_WAIT;
            end
          end else if (dec_jal) begin
            tgt_sel_s = TGT_PC_IMM;
            taken_s   = 1'b1;
            resolve_s = slot_free_s;
          end else if (dec_bxx) begin
            // Static prediction: backward branches taken.
            if (dec_immb[XLEN-1]) begin
              tgt_sel_s = TGT_PC_IMM;
              taken_s   = 1'b1;
            end else begin
              tgt_sel_s = TGT_SEQ;
              taken_s   = 1'b0;
            end
            resolve_s = slot_free_s;
          end else begin
            resolve_s = slot_free_s;
          end
        end
        ST_RS1_WAIT: begin
          tgt_sel_s = TGT_JALR;
          taken_s   = 1'b1;
          if (i_valid && rs1_ready_s && slot_free_s) begin
            resolve_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_RS1_WAIT;
          end
        end
        ST_CSR_WAIT: begin
          tgt_sel_s = TGT_CSR;
          taken_s   = 1'b1;
          if (i_valid && (csr_ack_s || csr_have_r) && slot_free_s) begin
            resolve_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_CSR_WAIT;
          end
        end
        ST_FENCEI_WAIT: begin
          tgt_sel_s = TGT_SEQ;
          taken_s   = 1'b0;
          if (i_valid && (fencei_done_s || fencei_done_r) && slot_free_s) begin
            resolve_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_FENCEI_WAIT;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, fetch PC and decode-side output register with valid/ready handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      fetch_pc     <= RESET_PC;
      o_valid      <= 1'b0;
      o_inst       <= {XLEN{1'b0}};
      o_pc         <= {XLEN{1'b0}};
      o_pred_taken <= 1'b0;
      o_pred_pc    <= {XLEN{1'b0}};
    end else if (flush_valid) begin
      state_r  <= ST_IDLE;
      fetch_pc <= flush_pc;
      o_valid  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (resolve_s) begin
        fetch_pc     <= target_s;
        o_valid      <= 1'b1;
        o_inst       <= i_inst;
        o_pc         <= i_pc;
        o_pred_taken <= taken_s;
        o_pred_pc    <= target_s;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  // CSR and fence.i request lines plus their stalled-completion latches.
  always_ff @(posedge clock) begin
    if (reset || flush_valid) begin
      csr_rd_req    <= 1'b0;
      fencei_req    <= 1'b0;
      csr_have_r    <= 1'b0;
      fencei_done_r <= 1'b0;
      if (reset) begin
        csr_rd_idx <= 12'h000;
        csr_data_r <= {XLEN{1'b0}};
      end
    end else begin
      if (csr_start_s) begin
        csr_rd_req <= 1'b1;
        csr_rd_idx <= dec_csridx;
      end else if (csr_ack_s) begin
        csr_rd_req <= 1'b0;
      end
      if (resolve_s) begin
        csr_have_r <= 1'b0;
      end else if (csr_ack_s) begin
        csr_have_r <= 1'b1;
        csr_data_r <= csr_rd_data;
      end
      if (fencei_start_s) begin
        fencei_req <= 1'b1;
      end else if (fencei_done_s) begin
        fencei_req <= 1'b0;
      end
      if (resolve_s) begin
        fencei_done_r <= 1'b0;
      end else if (fencei_done_s) begin
        fencei_done_r <= 1'b1;
      end
    end
  end

endmodule
